// File: rtl/weight_pkg.sv
// Shared constants, width helpers and FSM state type
// for the weight fetch path.
package weight_pkg;

    localparam int DEF_NUM_CHANNELS = 8;
    localparam int DEF_FILTER_SIZE  = 3;
    localparam int DEF_DATA_WIDTH   = 8;

    function automatic int kset_width(
        input int nc,
        input int fs,
        input int dw
    );
        return nc * fs * fs * dw;
    endfunction

    localparam int KERNEL_SET_WIDTH =
        kset_width(DEF_NUM_CHANNELS, DEF_FILTER_SIZE, DEF_DATA_WIDTH);
    localparam int BRAM_LINE_WIDTH = 2 * KERNEL_SET_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } wfs_state_e;

endpackage

// File: rtl/wfs_line_fifo.sv
// Two-entry line buffer between the BRAM read port
// and the PE-array stream; head is read combinationally.
module wfs_line_fifo #(
    parameter int W = 1153
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/weight_fetch_sequencer.sv
// Walks a line range of the weight BRAM and streams each line to the PE array.
// Define WFS_MULTIPASS_EN to repeat the range i_num_passes times.
module weight_fetch_sequencer
    import weight_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int FILTER_SIZE  = DEF_FILTER_SIZE,
    parameter int BRAM_DEPTH   = 512,
    localparam int ADDR_W = $clog2(BRAM_DEPTH),
    localparam int KSW    = kset_width(NUM_CHANNELS, FILTER_SIZE, DATA_WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_num_lines,
    input  logic [7:0]        i_num_passes,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_read_addr,
    output logic              o_read_en,
    input  logic [KSW-1:0]    i_kernels_A_packed,
    input  logic [KSW-1:0]    i_kernels_B_packed,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [KSW-1:0]    m_kernels_A,
    output logic [KSW-1:0]    m_kernels_B,
    output logic              m_last
);

    localparam int LW = 2 * KSW;

    wfs_state_e        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   lines_left;
    logic              rd_pending;
    logic              rd_last;
    logic [1:0]        fifo_count;
    logic [LW:0]       head;
    logic [2:0]        used;
    logic              pop;
    logic              issue;
    logic              final_pass;
    logic              end_of_pass;

`ifdef WFS_MULTIPASS_EN
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   lines;
    logic [7:0]        passes_left;
    assign final_pass = (passes_left == 8'd0);
`else
    logic unused_passes;
    assign unused_passes = ^i_num_passes;
    assign final_pass    = 1'b1;
`endif

    assign pop   = m_valid && m_ready;
    // Slots already claimed: buffered lines plus the one on the read bus.
    assign used  = {1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, pop};
    assign issue = (state == RUN) && (used < 3'd2);

    assign end_of_pass = (lines_left == (ADDR_W+1)'(1));
    assign o_read_en   = issue;
    assign o_read_addr = addr;

    assign m_valid     = (fifo_count != 2'd0);
    assign m_kernels_A = head[KSW-1:0];
    assign m_kernels_B = head[LW-1:KSW];
    assign m_last      = m_valid && head[LW];

    wfs_line_fifo #(
        .W (LW + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_pending),
        .pop   (pop),
        .wdata ({rd_last, i_kernels_B_packed, i_kernels_A_packed}),
        .rdata (head),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            lines_left <= '0;
            rd_pending <= 1'b0;
            rd_last    <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
`ifdef WFS_MULTIPASS_EN
            base        <= '0;
            lines       <= '0;
            passes_left <= 8'd0;
`endif
        end else begin
            rd_pending <= issue;
            rd_last    <= issue && end_of_pass && final_pass;
            o_done     <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (i_start) begin
                        addr       <= i_base_addr;
                        lines_left <= i_num_lines;
`ifdef WFS_MULTIPASS_EN
                        base        <= i_base_addr;
                        lines       <= i_num_lines;
                        passes_left <= (i_num_passes == 8'd0) ?
                                       8'd0 : i_num_passes - 8'd1;
`endif
                        if (i_num_lines == '0) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                        end else begin
                            state  <= RUN;
                            o_busy <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr       <= addr + ADDR_W'(1);
                        lines_left <= lines_left - (ADDR_W+1)'(1);
                        if (end_of_pass) begin
                            if (final_pass) begin
                                state <= DRAIN;
                            end else begin
`ifdef WFS_MULTIPASS_EN
                                addr        <= base;
                                lines_left  <= lines;
                                passes_left <= passes_left - 8'd1;
`endif
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head[LW]) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Directed scoreboard bench for weight_fetch_sequencer with a
// 1-cycle-latency BRAM model feeding the kernel inputs.
module tb_weight_fetch_sequencer;

    localparam int AW  = 9;
    localparam int KSW = 576;
    localparam int LW  = 2 * KSW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_start = 1'b0;
    logic [AW-1:0]  i_base_addr = '0;
    logic [AW:0]    i_num_lines = '0;
    logic [7:0]     i_num_passes = '0;
    logic           o_busy, o_done, o_read_en;
    logic [AW-1:0]  o_read_addr;
    logic [KSW-1:0] bram_a = '0;
    logic [KSW-1:0] bram_b = '0;
    logic           m_valid, m_last;
    logic           m_ready = 1'b1;
    logic [KSW-1:0] m_kernels_A, m_kernels_B;

    weight_fetch_sequencer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_start            (i_start),
        .i_base_addr        (i_base_addr),
        .i_num_lines        (i_num_lines),
        .i_num_passes       (i_num_passes),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_read_addr        (o_read_addr),
        .o_read_en          (o_read_en),
        .i_kernels_A_packed (bram_a),
        .i_kernels_B_packed (bram_b),
        .m_valid            (m_valid),
        .m_ready            (m_ready),
        .m_kernels_A        (m_kernels_A),
        .m_kernels_B        (m_kernels_B),
        .m_last             (m_last)
    );

    always #5 clk = ~clk;

    function automatic logic [KSW-1:0] line_a(input logic [AW-1:0] a);
        return {18{16'hA0A0, 7'd0, a}};
    endfunction

    function automatic logic [KSW-1:0] line_b(input logic [AW-1:0] a);
        return {18{16'h5B5B, 7'd0, ~a}};
    endfunction

    always @(posedge clk)
        if (o_read_en) begin
            bram_a <= line_a(o_read_addr);
            bram_b <= line_b(o_read_addr);
        end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int beats = 0;
    int reads = 0;
    int dones = 0;
    int last_fire = -10;
    int done_mark = 0;
    bit chk_lat = 1'b0;
    logic [LW:0]   exp_q [$];
    logic [AW-1:0] addr_q [$];

    task automatic check(input string tag, input logic [LW:0] obs,
                         input logic [LW:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h",
                   tag, obs[159:0], exp[159:0]);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [AW-1:0] ea;
        logic [LW:0]   eb;
        if (rst_n) begin
            if (o_read_en) begin
                reads++;
                ea = (addr_q.size() != 0) ? addr_q.pop_front() : 'x;
                check("read_addr", LW'(o_read_addr), LW'(ea));
            end
            if (m_valid && m_ready) begin
                beats++;
                last_fire = cyc;
                eb = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                check("beat", {m_last, m_kernels_B, m_kernels_A}, eb);
            end
            if (o_done) begin
                dones++;
                if (chk_lat)
                    check("done_latency", cyc, last_fire + 1);
            end
        end
    end

    task automatic start_run(input int base, input int n, input int passes);
        int np;
        logic [AW-1:0] a;
        np = 1;
`ifdef WFS_MULTIPASS_EN
        np = (passes == 0) ? 1 : passes;
`endif
        for (int p = 0; p < np; p++)
            for (int i = 0; i < n; i++) begin
                a = AW'(base + i);
                addr_q.push_back(a);
                exp_q.push_back({(p == np - 1) && (i == n - 1),
                                 line_b(a), line_a(a)});
            end
        chk_lat   = (n > 0);
        done_mark = dones;
        @(posedge clk);
        #1;
        i_start      = 1'b1;
        i_base_addr  = AW'(base);
        i_num_lines  = (AW+1)'(n);
        i_num_passes = 8'(passes);
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k;
        k = 0;
        while (dones == done_mark && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, dones - done_mark, 1);
        check({tag, "_queues"}, exp_q.size() + addr_q.size(), 0);
    endtask

    initial begin
        int r0, b0, d0, k;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {o_busy, o_done, o_read_en, m_valid, m_last}, 0);
        check("rst_addr", o_read_addr, 0);
        check("rst_kA", m_kernels_A, 0);
        check("rst_kB", m_kernels_B, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // basic two-line run
        b0 = beats;
        start_run(0, 2, 1);
        @(negedge clk);
        check("basic_rd0", {o_busy, o_read_en, o_read_addr}, {2'b11, 9'd0});
        @(negedge clk);
        check("basic_rd1", {o_read_en, o_read_addr}, {1'b1, 9'd1});
        wait_done(20, "basic_done");
        check("basic_beats", beats - b0, 2);
        @(negedge clk);
        check("basic_idle", {o_busy, o_done}, 0);

        // backpressure
        @(posedge clk);
        #1 m_ready = 1'b0;
        r0 = reads;
        b0 = beats;
        start_run(40, 6, 1);
        repeat (10) @(negedge clk);
        check("bp_reads", reads - r0, 2);
        check("bp_re_low", o_read_en, 0);
        check("bp_hold_a", {m_valid, m_last, m_kernels_A},
              {2'b10, line_a(9'd40)});
        check("bp_hold_b", m_kernels_B, line_b(9'd40));
        @(posedge clk);
        #1 m_ready = 1'b1;
        @(negedge clk);
        check("bp_resume", {o_read_en, o_read_addr}, {1'b1, 9'd42});
        wait_done(40, "bp_done");
        check("bp_beats", beats - b0, 6);

        // address wrap
        start_run(510, 4, 1);
        wait_done(30, "wrap_done");

        // zero length
        r0 = reads;
        b0 = beats;
        start_run(7, 0, 1);
        @(negedge clk);
        check("zero_flags", {o_done, o_busy, m_valid, o_read_en}, 4'b1000);
        wait_done(5, "zero_done");
        check("zero_reads", reads - r0, 0);
        check("zero_beats", beats - b0, 0);

        // start while busy is ignored
        b0 = beats;
        start_run(20, 5, 1);
        @(posedge clk);
        #1;
        i_start     = 1'b1;
        i_base_addr = 9'd100;
        i_num_lines = 10'd3;
        @(posedge clk);
        #1 i_start = 1'b0;
        wait_done(40, "busy_done");
        check("busy_beats", beats - b0, 5);

        // reset in the middle of a run
        d0 = dones;
        b0 = beats;
        start_run(60, 8, 1);
        k = 0;
        while (beats - b0 < 3 && k < 50) begin
            @(posedge clk);
            k++;
        end
        check("rst_mid_reach", beats - b0, 3);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_ctrl", {o_busy, o_done, o_read_en, m_valid, m_last}, 0);
        check("rst_mid_k", {m_kernels_B, m_kernels_A}, 0);
        check("rst_mid_addr", o_read_addr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        addr_q.delete();
        repeat (5) @(negedge clk);
        check("rst_mid_nodone", dones - d0, 0);
        b0 = beats;
        start_run(200, 3, 1);
        wait_done(30, "rst_fresh_done");
        check("rst_fresh_beats", beats - b0, 3);

`ifdef WFS_MULTIPASS_EN
        b0 = beats;
        start_run(4, 3, 2);
        wait_done(40, "mp_done");
        check("mp_beats", beats - b0, 6);
        b0 = beats;
        start_run(8, 2, 0);
        wait_done(30, "mp_zero_done");
        check("mp_zero_beats", beats - b0, 2);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
